// File: rtl/oldland_fetch_if.sv
// oldland_fetch_if: instruction memory request/acknowledge bus
interface oldland_fetch_if;
  logic [31:0] i_addr;
  logic        i_access;
  logic        i_ack;
  logic [31:0] i_data;
  modport master (output i_addr, i_access, input i_ack, i_data);
  modport slave (input i_addr, i_access, output i_ack, i_data);
endinterface

// File: rtl/oldland_fetch.sv
// oldland_fetch: instruction fetch with a 2-entry prefetch buffer, decode bypass and branch flush
module oldland_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic            clk,
  input  logic            rst_n,
  oldland_fetch_if.master mem,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [31:0]     branch_pc,
  output logic [31:0]     instr,
  output logic [31:0]     pc_plus_4,
  output logic            instr_valid
);
  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n, addr_n, instr_n, pcp4_n;
  logic [31:0] buf_word [2];
  logic [31:0] buf_pc [2];
  logic [1:0]  count, count_n;
  logic access_n, valid_n, ack, kept, done, pop, bypass, push, issue, wi;
  // next state: buffer bookkeeping, issue decision and decode outputs
  always_comb begin
    ack = mem.i_ack && state != IDLE;
    kept = ack && state == REQ && !branch_taken;
    done = state == IDLE || ack;
    pop = !branch_taken && !stall && count != 2'd0;
    bypass = !branch_taken && !stall && count == 2'd0 && kept;
    push = kept && !bypass;
    wi = count[1] || (count[0] && !pop);
    count_n = branch_taken ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    fetch_pc_n = branch_taken ? (branch_pc & ~32'h3) : kept ? fetch_pc + 32'd4 : fetch_pc;
    issue = done && count_n != 2'd2;
    state_n = issue ? REQ : done ? IDLE : branch_taken ? FLUSH : state;
    access_n = state_n != IDLE;
    addr_n = issue ? fetch_pc_n : mem.i_addr;
    instr_n = pop ? buf_word[0] : bypass ? mem.i_data : (stall && !branch_taken) ? instr : NOP_INSTR;
    pcp4_n = pop ? buf_pc[0] : bypass ? mem.i_addr + 32'd4 : pc_plus_4;
    valid_n = pop || bypass || (stall && !branch_taken && instr_valid);
  end
  // controller state, fetch address, bus request and decode output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      count <= 2'd0;
      mem.i_access <= 1'b0;
      mem.i_addr <= RESET_PC;
      instr <= NOP_INSTR;
      pc_plus_4 <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      count <= count_n;
      mem.i_access <= access_n;
      mem.i_addr <= addr_n;
      instr <= instr_n;
      pc_plus_4 <= pcp4_n;
      instr_valid <= valid_n;
    end
  // buffer storage: head shifts down on pop, new word lands after the survivors
  always_ff @(posedge clk) begin
    if (pop) begin
      buf_word[0] <= buf_word[1];
      buf_pc[0] <= buf_pc[1];
    end
    if (push) begin
      buf_word[wi] <= mem.i_data;
      buf_pc[wi] <= mem.i_addr + 32'd4;
    end
  end
endmodule

// File: tb/tb_oldland_fetch.sv
// tb_oldland_fetch: scoreboard bench for the fetch stage against a queued memory model
module tb_oldland_fetch;
  localparam logic [31:0] K = 32'hA5A5A5A5;
  logic clk = 0, rst_n = 0, stall = 0, branch_taken = 0;
  logic [31:0] branch_pc = 0, instr, pc_plus_4, m_data = 0;
  logic instr_valid, m_ack = 0, x_ack = 0, ms, mb, mr;
  int lat = 0, wcnt = 0, acks = 0, a0 = 0, errors = 0, checks = 0;
  logic [31:0] addr_q[$];
  logic [63:0] out_q[$];
  logic [63:0] e;

  oldland_fetch_if bus();
  assign bus.i_ack = m_ack | x_ack;
  assign bus.i_data = m_data;

  oldland_fetch dut (.clk(clk), .rst_n(rst_n), .mem(bus.master), .stall(stall),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .instr(instr),
    .pc_plus_4(pc_plus_4), .instr_valid(instr_valid));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory: acks only addresses the stimulus queued, after lat wait cycles
  always @(negedge clk) begin
    m_ack = 0;
    if (bus.i_access && addr_q.size() != 0) begin
      if (wcnt >= lat) begin
        chk("i_addr", bus.i_addr, addr_q.pop_front());
        m_ack = 1;
        m_data = bus.i_addr ^ K;
        wcnt = 0;
        acks++;
      end else wcnt++;
    end else wcnt = 0;
  end

  // monitor: every unstalled, non-branch edge with instr_valid is a fresh instruction
  always begin
    @(posedge clk);
    ms = stall; mb = branch_taken; mr = rst_n;
    #1;
    if (mr && !ms && !mb && instr_valid) begin
      if (out_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected output: instr %h pc_plus_4 %h, expected none", instr, pc_plus_4);
      end else begin
        e = out_q.pop_front();
        chk("instr", instr, e[63:32]);
        chk("pc_plus_4", pc_plus_4, e[31:0]);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] a);
    addr_q.push_back(a);
    out_q.push_back({a ^ K, a + 32'd4});
  endtask

  task automatic drain;
    int n = 0;
    while ((out_q.size() != 0 || addr_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain timeout: %0d outputs pending, expected 0", out_q.size());
      out_q.delete();
      addr_q.delete();
    end
    tick();
  endtask

  task automatic do_reset;
    rst_n = 0; stall = 0; branch_taken = 0; lat = 0;
    tick(2);
    rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // zero-wait streaming
    do_reset();
    chk("reset i_access", {31'b0, bus.i_access}, 0);
    chk("reset instr_valid", {31'b0, instr_valid}, 0);
    for (int i = 0; i < 12; i++) expect_word(4 * i);
    tick();
    chk("first i_access", {31'b0, bus.i_access}, 1);
    chk("first i_addr", bus.i_addr, 32'h0);
    chk("first instr_valid", {31'b0, instr_valid}, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stream i_access", {31'b0, bus.i_access}, 1);
    end
    drain();
    chk("bubble instr_valid", {31'b0, instr_valid}, 0);
    chk("bubble instr", instr, 32'h0);
    chk("bubble pc_plus_4 hold", pc_plus_4, 32'd48);
    chk("outstanding i_addr", bus.i_addr, 32'd48);

    // stall mid-stream
    do_reset();
    for (int i = 0; i < 12; i++) expect_word(4 * i);
    tick(4);
    stall = 1;
    a0 = acks;
    tick(5);
    chk("stall acks", acks - a0, 2);
    chk("stall i_access", {31'b0, bus.i_access}, 0);
    chk("stall instr_valid", {31'b0, instr_valid}, 1);
    chk("stall instr", instr, 32'h8 ^ K);
    chk("stall pc_plus_4", pc_plus_4, 32'hC);
    stall = 0;
    drain();

    // branch while request outstanding, late ack goes to FLUSH
    do_reset();
    for (int i = 0; i < 4; i++) expect_word(4 * i);
    drain();
    chk("pre-branch i_addr", bus.i_addr, 32'h10);
    lat = 3;
    addr_q.push_back(32'h10);
    expect_word(32'h1000);
    expect_word(32'h1004);
    branch_taken = 1; branch_pc = 32'h1003;
    tick();
    branch_taken = 0;
    chk("branch bubble", {31'b0, instr_valid}, 0);
    chk("flush i_access", {31'b0, bus.i_access}, 1);
    chk("flush i_addr held", bus.i_addr, 32'h10);
    drain();

    // branch coincident with ack under stall
    do_reset();
    expect_word(0);
    expect_word(4);
    tick(3);
    chk("pre-stall instr_valid", {31'b0, instr_valid}, 1);
    addr_q.push_back(32'h8);
    stall = 1; branch_taken = 1; branch_pc = 32'h2000;
    tick();
    branch_taken = 0;
    chk("branch-ack instr_valid", {31'b0, instr_valid}, 0);
    chk("branch-ack instr", instr, 32'h0);
    chk("branch-ack i_access", {31'b0, bus.i_access}, 1);
    chk("branch-ack i_addr", bus.i_addr, 32'h2000);
    expect_word(32'h2000);
    expect_word(32'h2004);
    tick(4);
    chk("stalled bubble", {31'b0, instr_valid}, 0);
    stall = 0;
    drain();

    // reset mid-request, then a late ack
    do_reset();
    expect_word(0);
    drain();
    chk("pre-reset i_addr", bus.i_addr, 32'h4);
    rst_n = 0;
    #1;
    chk("async i_access", {31'b0, bus.i_access}, 0);
    chk("async i_addr", bus.i_addr, 32'h0);
    chk("async instr", instr, 32'h0);
    chk("async instr_valid", {31'b0, instr_valid}, 0);
    chk("async pc_plus_4", pc_plus_4, 32'h0);
    tick(2);
    rst_n = 1;
    @(negedge clk);
    x_ack = 1;
    tick();
    x_ack = 0;
    chk("late-ack i_access", {31'b0, bus.i_access}, 1);
    chk("late-ack i_addr", bus.i_addr, 32'h0);
    chk("late-ack instr_valid", {31'b0, instr_valid}, 0);
    expect_word(0);
    drain();

    // address wrap
    do_reset();
    tick(2);
    addr_q.push_back(32'h0);
    expect_word(32'hFFFFFFF8);
    expect_word(32'hFFFFFFFC);
    branch_taken = 1; branch_pc = 32'hFFFFFFF8;
    tick();
    branch_taken = 0;
    drain();
    chk("wrap i_addr", bus.i_addr, 32'h0);
    chk("wrap pc_plus_4", pc_plus_4, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/oldland_fetch.md
# oldland_fetch

Instruction fetch stage for the oldland pipeline. It issues word reads to instruction memory over a request/acknowledge handshake and buffers up to two fetched words. Each cycle it hands one instruction and its PC+4 to the decode stage, or a bubble when none is ready. It honours pipeline stalls and discards in-flight fetches when execute redirects the PC on a taken branch.

## Interface
Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset (word aligned).
- NOP_INSTR, 32'h00000000, encoding driven on instr during bubbles.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_addr  out  32  fetch address; bits [1:0] always 0.
- i_access  out  1  read request; held with i_addr stable until i_ack.
- i_ack  in  1  one-cycle pulse completing the request; i_data valid in the same cycle.
- i_data  in  32  instruction word.
- stall  in  1  decode cannot accept; hold outputs.
- branch_taken  in  1  redirect request, single cycle.
- branch_pc  in  32  redirect target; bits [1:0] ignored.
- instr  out  32  instruction to decode.
- pc_plus_4  out  32  address of instr + 4.
- instr_valid  out  1  instr is a real fetched word, not a bubble.

## Operation
- Buffer: 2-entry FIFO of {word, pc}. Count 0..2. At most one memory request outstanding.
- Controller states:
  - IDLE: nothing outstanding.
  - REQ: outstanding, data kept.
  - FLUSH: outstanding, data discarded.
- Issue rule: a new request (i_access=1, i_addr=fetch_pc) may begin at an edge only if next-cycle FIFO count + 1 ≤ 2. On issue, fetch_pc advances by 4 when the request completes with data kept.
- On i_ack in REQ: the word is pushed with its pc. Exception: bypass (below). Then either re-issue at the next address the same edge, keeping i_access high, or go to IDLE.
- Output pop, when stall=0: instr/pc_plus_4 <= FIFO head, instr_valid <= 1, head popped.
  - Bypass: if the FIFO is empty and i_ack arrives in REQ, i_data goes straight to the outputs at that edge.
  - Nothing available: instr <= NOP_INSTR, instr_valid <= 0; pc_plus_4 holds.
- stall=1: instr, pc_plus_4 and instr_valid hold. Fetch continues until the FIFO is full.
- branch_taken=1 (overrides stall):
  - FIFO is cleared.
  - Outputs become a bubble at that edge.
  - fetch_pc <= {branch_pc[31:2], 2'b00}.
  - From REQ without i_ack: go to FLUSH. i_access and i_addr stay unchanged, as the protocol forbids withdrawal.
  - From REQ with i_ack that cycle: the word is dropped and a request to the target is issued at that edge.
  - From IDLE: issue to the target at that edge.
  - In FLUSH: only fetch_pc is updated.
- FLUSH on i_ack: word dropped, FIFO stays empty, and a request to fetch_pc is issued at the same edge, entering REQ.
- Address arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.
- Reset (asynchronous, any state):
  - i_access=0, i_addr=RESET_PC.
  - instr=NOP_INSTR, instr_valid=0, pc_plus_4=32'h0.
  - FIFO empty, state IDLE, fetch_pc=RESET_PC.
  - An outstanding ack arriving after reset is ignored, because IDLE discards unsolicited acks.

## Timing
- First edge after rst_n rises: i_access=1, i_addr=RESET_PC.
- Zero-wait memory (i_ack in the cycle after i_access rises), no stall: instr_valid at the edge where i_ack is sampled. Steady state is one instruction per cycle with i_access held continuously high.
- Redirect latency: a request to the target appears at the branch edge from IDLE. From REQ/FLUSH, it appears at the edge where the old ack arrives. The target word reaches the outputs at its own ack edge.
- FIFO full with stall=1: no request issued; i_access low after the completing ack.

## Test plan
- Reset, zero-wait memory returning i_data=addr^32'hA5A5A5A5, no stall -> i_addr sequence 0,4,8,…; instr_valid=1 from the first ack edge; pc_plus_4=4,8,12 back-to-back.
- stall=1 for 5 cycles mid-stream -> outputs frozen; exactly two further words buffered, then i_access=0; on release, the buffered words emerge in order with no gaps or duplicates.
- branch_taken with branch_pc=32'h1003 while a request to 0x10 is outstanding, ack 3 cycles later -> that word is dropped; the next i_addr is 32'h1000; the first valid instr is the word at 0x1000 with pc_plus_4=32'h1004.
- branch_taken in the same cycle as i_ack, with stall=1 -> the acked word is dropped; the outputs become a bubble despite stall; a request to the target is issued at that edge.
- rst_n asserted low while a request is outstanding, then a late i_ack -> all outputs reach their reset values immediately; the late ack is ignored; the first request after release is to RESET_PC.
- fetch_pc=32'hFFFFFFF8, zero-wait memory -> i_addr is FFFFFFF8, FFFFFFFC, 00000000; the final pc_plus_4 is 32'h00000000.
